eds_line_packer: RTL and testbench

- Downstream of the EDS image receiver: consumes its per-beat stream (lval plus LANES×16-bit pixel words; lane 0 bits [15:12] = 4'hF marks the first beat of a line).
- Frames the stream into whole lines tagged with start-of-frame, start-of-line and end-of-line flags.
- Writes the lines into the external DDR-bound write FIFO.
- The sensor stream cannot be stalled, so the block drops whole lines when the FIFO lacks room, and keeps error and drop statistics.

---
 rtl/eds_line_packer.sv | 142 ++++++++++++++
 tb/tb_eds_line_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eds_line_packer.sv
// eds_line_packer: frames the EDS receiver beat stream into whole tagged lines
// and writes them to the DDR write FIFO, dropping whole lines when it lacks room.
`timescale 1ns/1ps
module eds_line_packer #(
  parameter int LANES      = 8,
  parameter int DATA_W     = LANES*16,
  parameter int LINE_BEATS = 256,
  parameter int CNT_W      = 16
) (
  input  logic              clk_rxg,
  input  logic              rst_rx,
  input  logic              eds_frame_en,
  input  logic              lval_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_prog_full,
  input  logic              clr_stat,
  output logic              fifo_wr_en,
  output logic [DATA_W+2:0] fifo_din,
  output logic [CNT_W-1:0]  line_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t            state, state_n;
  logic [BEAT_W-1:0] beat_cnt, beat_n;
  logic              frame_first, first_n;
  logic              frame_en_d;
  logic [CNT_W-1:0]  line_n, err_n, drop_n;
  logic              wr_n, sof_n, sol_n, eol_n;
  logic              err_inc, drop_inc, line_start;
  logic              frame_rise, start;

  assign frame_rise = eds_frame_en & ~frame_en_d;
  assign start      = lval_in & (data_in[15:12] == 4'hF);

  always_comb begin
    state_n    = state;
    beat_n     = beat_cnt;
    first_n    = frame_first;
    line_n     = line_cnt;
    wr_n       = 1'b0;
    sof_n      = 1'b0;
    sol_n      = 1'b0;
    eol_n      = 1'b0;
    err_inc    = 1'b0;
    drop_inc   = 1'b0;
    line_start = 1'b0;

    if (frame_rise) begin
      state_n = IDLE;
      beat_n  = '0;
      line_n  = '0;
      first_n = 1'b1;
    end else if (!eds_frame_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start)        line_start = 1'b1;
          else if (lval_in) err_inc    = 1'b1;
        end
        PASS, DROP: begin
          if (start) begin
            // Short line: the truncated line is abandoned without eol.
            err_inc    = 1'b1;
            line_start = 1'b1;
          end else if (lval_in) begin
            wr_n = (state == PASS);
            if (beat_cnt == LAST_BEAT) begin
              eol_n   = (state == PASS);
              if (state == PASS) line_n = line_cnt + CNT_W'(1);
              beat_n  = '0;
              state_n = IDLE;
            end else begin
              beat_n = beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase

      // Room is only judged at line start; an accepted line always completes.
      if (line_start) begin
        beat_n = BEAT_W'(1);
        if (!fifo_prog_full) begin
          wr_n    = 1'b1;
          sol_n   = 1'b1;
          sof_n   = frame_first;
          first_n = 1'b0;
          state_n = PASS;
        end else begin
          drop_inc = 1'b1;
          state_n  = DROP;
        end
      end
    end

    err_n  = err_cnt;
    drop_n = drop_cnt;
    if (clr_stat) begin
      err_n  = '0;
      drop_n = '0;
    end else begin
      if (err_inc  && (err_cnt  != CNT_MAX)) err_n  = err_cnt  + CNT_W'(1);
      if (drop_inc && (drop_cnt != CNT_MAX)) drop_n = drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_rxg) begin
    if (rst_rx) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      frame_first <= 1'b0;
      frame_en_d  <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= '0;
      line_cnt    <= '0;
      err_cnt     <= '0;
      drop_cnt    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_n;
      frame_first <= first_n;
      frame_en_d  <= eds_frame_en;
      fifo_wr_en  <= wr_n;
      if (wr_n) fifo_din <= {sof_n, sol_n, eol_n, data_in};
      line_cnt    <= line_n;
      err_cnt     <= err_n;
      drop_cnt    <= drop_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_eds_line_packer.sv
// Directed self-checking bench for eds_line_packer: line framing, gaps, drops,
// short lines, stray beats and frame-enable control cases.
`timescale 1ns/1ps
module tb_eds_line_packer;

  localparam int LANES      = 8;
  localparam int DATA_W     = LANES*16;
  localparam int LINE_BEATS = 256;
  localparam int CNT_W      = 16;

  logic              clk_rxg = 1'b0;
  logic              rst_rx;
  logic              eds_frame_en;
  logic              lval_in;
  logic [DATA_W-1:0] data_in;
  logic              fifo_prog_full;
  logic              clr_stat;
  logic              fifo_wr_en;
  logic [DATA_W+2:0] fifo_din;
  logic [CNT_W-1:0]  line_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_cnt = 0, sof_cnt = 0, sol_cnt = 0, eol_cnt = 0;
  int base_wr, base_sof, base_sol, base_eol;

  eds_line_packer #(
    .LANES(LANES), .DATA_W(DATA_W), .LINE_BEATS(LINE_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk_rxg(clk_rxg), .rst_rx(rst_rx), .eds_frame_en(eds_frame_en),
    .lval_in(lval_in), .data_in(data_in), .fifo_prog_full(fifo_prog_full),
    .clr_stat(clr_stat), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .line_cnt(line_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk_rxg = ~clk_rxg;

  // Write monitor, sampled on the falling edge between registered updates.
  always @(negedge clk_rxg) begin
    if (fifo_wr_en) begin
      wr_cnt  = wr_cnt + 1;
      sof_cnt = sof_cnt + int'(fifo_din[DATA_W+2]);
      sol_cnt = sol_cnt + int'(fifo_din[DATA_W+1]);
      eol_cnt = eol_cnt + int'(fifo_din[DATA_W]);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] beat_data(input int idx, input bit marker);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int l = 1; l < LANES; l++) d[l*16 +: 16] = 16'(idx*37 + l*4099);
    d[15:0] = {(marker ? 4'hF : 4'h0), 12'(idx)};
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W+2:0] observed,
                             input logic [DATA_W+2:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock of input; returns just after the edge so registered outputs reflect it.
  task automatic applyStimulus(input logic lval, input logic [DATA_W-1:0] d);
    lval_in = lval;
    data_in = d;
    @(posedge clk_rxg);
    #1;
    lval_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0);
  endtask

  // Beat 0 carries the line marker; optional lval gap after beat gap_after.
  task automatic send_beats(input int first, input int n, input int gap_after,
                            input int gap_len);
    for (int i = first; i < first + n; i++) begin
      applyStimulus(1'b1, beat_data(i, i == 0));
      if (i == gap_after) idle(gap_len);
    end
  endtask

  task automatic new_frame();
    eds_frame_en = 1'b0;
    idle(1);
    eds_frame_en = 1'b1;
    idle(2);
  endtask

  task automatic snap();
    base_wr  = wr_cnt;
    base_sof = sof_cnt;
    base_sol = sol_cnt;
    base_eol = eol_cnt;
  endtask

  initial begin
    rst_rx = 1'b1; eds_frame_en = 1'b0; lval_in = 1'b0; data_in = '0;
    fifo_prog_full = 1'b0; clr_stat = 1'b0;
    idle(3);
    checkOutput("reset wr_en", fifo_wr_en, 0);
    checkOutput("reset din", fifo_din, 0);
    checkOutput("reset line_cnt", line_cnt, 0);
    checkOutput("reset err_cnt", err_cnt, 0);
    checkOutput("reset drop_cnt", drop_cnt, 0);
    checkOutput("reset busy", busy, 0);
    rst_rx = 1'b0;
    idle(1);

    // One contiguous line
    new_frame();
    snap();
    applyStimulus(1'b1, beat_data(0, 1'b1));
    checkOutput("l1 first wr_en", fifo_wr_en, 1);
    checkOutput("l1 first din", fifo_din, {3'b110, beat_data(0, 1'b1)});
    send_beats(1, LINE_BEATS - 2, -1, 0);
    checkOutput("l1 busy mid", busy, 1);
    applyStimulus(1'b1, beat_data(LINE_BEATS - 1, 1'b0));
    checkOutput("l1 last din", fifo_din, {3'b001, beat_data(LINE_BEATS - 1, 1'b0)});
    checkOutput("l1 busy end", busy, 0);
    checkOutput("l1 line_cnt", line_cnt, 1);
    idle(2);
    checkOutput("l1 writes", wr_cnt - base_wr, LINE_BEATS);
    checkOutput("l1 sof", sof_cnt - base_sof, 1);
    checkOutput("l1 eol", eol_cnt - base_eol, 1);
    checkOutput("l1 err_cnt", err_cnt, 0);

    // Two lines with mid-line gaps
    new_frame();
    checkOutput("frame line_cnt clr", line_cnt, 0);
    snap();
    send_beats(0, LINE_BEATS, 50, 3);
    applyStimulus(1'b1, beat_data(0, 1'b1));
    checkOutput("l2 second sol", fifo_din[DATA_W+2:DATA_W], 3'b010);
    send_beats(1, LINE_BEATS - 1, 120, 3);
    idle(2);
    checkOutput("gap writes", wr_cnt - base_wr, 2*LINE_BEATS);
    checkOutput("gap sof", sof_cnt - base_sof, 1);
    checkOutput("gap sol", sol_cnt - base_sol, 2);
    checkOutput("gap eol", eol_cnt - base_eol, 2);
    checkOutput("gap line_cnt", line_cnt, 2);

    // Drop when FIFO full at line start
    new_frame();
    snap();
    fifo_prog_full = 1'b1;
    applyStimulus(1'b1, beat_data(0, 1'b1));
    fifo_prog_full = 1'b0;
    checkOutput("drop busy", busy, 1);
    send_beats(1, LINE_BEATS - 1, -1, 0);
    idle(2);
    checkOutput("drop writes", wr_cnt - base_wr, 0);
    checkOutput("drop drop_cnt", drop_cnt, 1);
    applyStimulus(1'b1, beat_data(0, 1'b1));
    checkOutput("after drop sof", fifo_din[DATA_W+2:DATA_W], 3'b110);
    send_beats(1, LINE_BEATS - 1, -1, 0);
    idle(2);
    checkOutput("after drop writes", wr_cnt - base_wr, LINE_BEATS);
    checkOutput("after drop line_cnt", line_cnt, 1);

    // Marker reappears at beat 100
    new_frame();
    snap();
    send_beats(0, 100, -1, 0);
    applyStimulus(1'b1, beat_data(100, 1'b1));
    checkOutput("short err_cnt", err_cnt, 1);
    checkOutput("short restart din", fifo_din, {3'b010, beat_data(100, 1'b1)});
    send_beats(1, LINE_BEATS - 1, -1, 0);
    idle(2);
    checkOutput("short writes", wr_cnt - base_wr, 100 + LINE_BEATS);
    checkOutput("short eol", eol_cnt - base_eol, 1);
    checkOutput("short line_cnt", line_cnt, 1);

    // Statistics clear
    clr_stat = 1'b1;
    idle(1);
    clr_stat = 1'b0;
    checkOutput("clr err_cnt", err_cnt, 0);
    checkOutput("clr drop_cnt", drop_cnt, 0);

    // Stray unmarked beats before a valid line
    new_frame();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, beat_data(i + 1, 1'b0));
    checkOutput("stray err_cnt", err_cnt, 5);
    checkOutput("stray busy", busy, 0);
    snap();
    send_beats(0, LINE_BEATS, -1, 0);
    idle(2);
    checkOutput("stray line writes", wr_cnt - base_wr, LINE_BEATS);
    checkOutput("stray line_cnt", line_cnt, 1);
    checkOutput("stray err hold", err_cnt, 5);

    // frame_rise coincident with a marked beat
    eds_frame_en = 1'b0;
    idle(1);
    eds_frame_en = 1'b1;
    applyStimulus(1'b1, beat_data(0, 1'b1));
    checkOutput("rise beat wr_en", fifo_wr_en, 0);
    checkOutput("rise beat busy", busy, 0);
    checkOutput("rise beat err_cnt", err_cnt, 5);

    // eds_frame_en dropped mid-line
    snap();
    send_beats(0, 50, -1, 0);
    checkOutput("en low busy before", busy, 1);
    eds_frame_en = 1'b0;
    applyStimulus(1'b1, beat_data(50, 1'b0));
    checkOutput("en low wr_en", fifo_wr_en, 0);
    checkOutput("en low busy", busy, 0);
    send_beats(51, 3, -1, 0);
    idle(2);
    checkOutput("en low writes", wr_cnt - base_wr, 50);
    checkOutput("en low err hold", err_cnt, 5);

    // clr_stat coincident with an error
    eds_frame_en = 1'b1;
    idle(1);
    clr_stat = 1'b1;
    applyStimulus(1'b1, beat_data(7, 1'b0));
    clr_stat = 1'b0;
    checkOutput("clr+err err_cnt", err_cnt, 0);
    applyStimulus(1'b1, beat_data(8, 1'b0));
    checkOutput("err after clr", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
